// File: rtl/bus_proto_pkg.sv
// rtl/bus_proto_pkg.sv - serial bus protocol types and constants shared by masters and slaves
package bus_proto_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    MISS,
    WDATA,
    WPAR,
    TURN,
    RDATA,
    RPAR,
    DONE
  } state_e;

  localparam int SLAVE_ID_WIDTH = 3;
  localparam int ID_MSB         = 14;
  localparam int ID_LSB         = ID_MSB - SLAVE_ID_WIDTH + 1;

  // Open-drain bus: a node only ever pulls low or lets go.
  localparam logic BUS_RELEASE = 1'bz;
  localparam logic BUS_DRIVE0  = 1'b0;

endpackage

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - loadable MSB-first shift register with a per-state bit counter
module serial_shifter #(
  parameter int W  = 15,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          shift_i,
  input  logic          load_i,
  input  logic [W-1:0]  load_val_i,
  input  logic          bit_i,
  output logic [W-1:0]  sr_o,
  output logic [CW-1:0] cnt_o
);

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // clr only zeroes the counter so a captured byte survives a state change.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = load_val_i;
      cnt_d = '0;
    end else begin
      if (shift_i) sr_d = {sr_q[W-2:0], bit_i};
      if (clr_i) begin
        cnt_d = '0;
      end else if (shift_i && (cnt_q != '1)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sr_o  = sr_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - serial bus slave with a local byte register file
// Optional parity bit on data frames when BUS_PARITY_EN is defined.
module bus_mem_responder
  import bus_proto_pkg::*;
#(
  parameter int                        ADDRS_WIDTH    = 15,
  parameter int                        DATA_WIDTH     = 8,
  parameter logic [SLAVE_ID_WIDTH-1:0] SELF_ID        = 3'b010,
  parameter int                        MEM_ADDR_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_wrt,
  input  logic                      bus_util,
  inout  wire                       data_bus_serial,
  output logic                      slave_busy,
  input  logic [MEM_ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]     dbg_data,
  output logic                      par_err
);

  localparam int             CW        = $clog2(ADDRS_WIDTH + 1);
  localparam logic [CW-1:0]  ADDR_LAST = CW'(ADDRS_WIDTH - 2);
  localparam logic [CW-1:0]  DATA_LAST = CW'(DATA_WIDTH - 1);

  state_e                    state_q, state_d;
  logic                      busy_q, busy_d;
  logic [MEM_ADDR_WIDTH-1:0] la_q, la_d;
  logic [DATA_WIDTH-1:0]     dbg_q;
  logic [DATA_WIDTH-1:0]     mem [2**MEM_ADDR_WIDTH];
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      sh_clr, sh_shift, sh_load;
  logic [ADDRS_WIDTH-1:0]    sh_q;
  logic [CW-1:0]             cnt;
  logic [ADDRS_WIDTH-1:0]    frame;
  logic                      bus_bit;
  logic                      drive0;
  logic                      unused_bits;
`ifdef BUS_PARITY_EN
  logic                      perr_q, perr_d;
`endif

  assign bus_bit     = data_bus_serial;
  // The bit on the bus this cycle completes whatever field is being shifted in.
  assign frame       = {sh_q[ADDRS_WIDTH-2:0], bus_bit};
  assign unused_bits = ^{sh_q[ADDRS_WIDTH-1], frame[ID_LSB-1:DATA_WIDTH]};

  serial_shifter #(
    .W  (ADDRS_WIDTH),
    .CW (CW)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (sh_clr),
    .shift_i    (sh_shift),
    .load_i     (sh_load),
    .load_val_i (ADDRS_WIDTH'(mem[la_q])),
    .bit_i      (bus_bit),
    .sr_o       (sh_q),
    .cnt_o      (cnt)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    la_d      = la_q;
    mem_we    = 1'b0;
    mem_wdata = frame[DATA_WIDTH-1:0];
    sh_clr    = 1'b0;
    sh_shift  = 1'b0;
    sh_load   = 1'b0;
`ifdef BUS_PARITY_EN
    perr_d    = 1'b0;
`endif
    if ((state_q != IDLE) && !bus_util) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      sh_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (bus_util) begin
          sh_shift = 1'b1;
          sh_clr   = 1'b1;
          state_d  = ADDR;
        end
        ADDR: begin
          if (cnt == ADDR_LAST) begin
            sh_clr = 1'b1;
            if (frame[ID_MSB:ID_LSB] == SELF_ID) begin
              busy_d  = 1'b1;
              la_d    = frame[MEM_ADDR_WIDTH-1:0];
              state_d = rd_wrt ? WDATA : TURN;
            end else begin
              state_d = MISS;
            end
          end else begin
            sh_shift = 1'b1;
          end
        end
        MISS: ;
        WDATA: begin
          sh_shift = 1'b1;
          if (cnt == DATA_LAST) begin
            sh_clr = 1'b1;
`ifdef BUS_PARITY_EN
            state_d = WPAR;
`else
            mem_we  = 1'b1;
            state_d = DONE;
`endif
          end
        end
`ifdef BUS_PARITY_EN
        WPAR: begin
          sh_clr  = 1'b1;
          state_d = DONE;
          if (bus_bit == ^sh_q[DATA_WIDTH-1:0]) begin
            mem_we    = 1'b1;
            mem_wdata = sh_q[DATA_WIDTH-1:0];
          end else begin
            perr_d = 1'b1;
          end
        end
`endif
        TURN: begin
          sh_load = 1'b1;
          state_d = RDATA;
        end
        RDATA: begin
          sh_shift = 1'b1;
          if (cnt == DATA_LAST) begin
            sh_clr = 1'b1;
`ifdef BUS_PARITY_EN
            state_d = RPAR;
`else
            state_d = DONE;
`endif
          end
        end
`ifdef BUS_PARITY_EN
        RPAR: begin
          sh_clr  = 1'b1;
          state_d = DONE;
        end
`endif
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    drive0 = (state_q == RDATA) && !sh_q[DATA_WIDTH-1];
`ifdef BUS_PARITY_EN
    if (state_q == RPAR) drive0 = !(^mem[la_q]);
`endif
  end

  assign data_bus_serial = drive0 ? BUS_DRIVE0 : BUS_RELEASE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      la_q    <= '0;
      dbg_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      la_q    <= la_d;
      dbg_q   <= mem[dbg_addr];
    end
  end

  // Register file contents persist across reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[la_q] <= mem_wdata;
  end

`ifdef BUS_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end
  assign par_err = perr_q;
`else
  assign par_err = 1'b0;
`endif

  assign slave_busy = busy_q;
  assign dbg_data   = dbg_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb/tb_bus_mem_responder.sv - scoreboard bench for bus_mem_responder
module tb_bus_mem_responder;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       rd_wrt   = 1'b0;
  logic       bus_util = 1'b0;
  logic       m_drv0   = 1'b0;
  logic [5:0] dbg_addr = 6'd0;
  logic       slave_busy;
  logic [7:0] dbg_data;
  logic       par_err;
  wire        bus;

  pullup (bus);
  assign bus = m_drv0 ? 1'b0 : 1'bz;

  bus_mem_responder dut (
    .clk             (clk),
    .rst             (rst),
    .rd_wrt          (rd_wrt),
    .bus_util        (bus_util),
    .data_bus_serial (bus),
    .slave_busy      (slave_busy),
    .dbg_addr        (dbg_addr),
    .dbg_data        (dbg_data),
    .par_err         (par_err)
  );

  always #5 clk = ~clk;

  localparam int K_BUSY = 0;
  localparam int K_BUS  = 1;
  localparam int K_DBG  = 2;
  localparam int K_PERR = 3;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } item_t;

  item_t      exp_q[$];
  logic [7:0] byte_q[$];
  int         probe_n  = 0;
  logic       rd_phase = 1'b0;
  int         checks   = 0;
  int         errors   = 0;
`ifdef BUS_PARITY_EN
  bit         bad_par  = 1'b0;
`endif

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  initial begin
    item_t      it;
    logic [7:0] act;
    logic [7:0] sh;
    int         nb;
    sh = 8'h00;
    nb = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < probe_n; i++) begin
        it = exp_q.pop_front();
        case (it.kind)
          K_BUSY:  act = {7'b0, slave_busy};
          K_BUS:   act = {7'b0, bus};
          K_DBG:   act = dbg_data;
          default: act = {7'b0, par_err};
        endcase
        check(it.name, act, it.exp);
      end
      probe_n = 0;
      if (rd_phase) begin
        sh = {sh[6:0], bus};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (byte_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_byte: got %h with no byte expected", sh);
          end else begin
            check("read_byte", sh, byte_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int k, input logic [7:0] e, input string n);
    exp_q.push_back('{k, e, n});
    probe_n++;
  endtask

  task automatic send_addr(input logic [14:0] a, input logic rw);
    rd_wrt   = rw;
    bus_util = 1'b1;
    for (int i = 14; i >= 0; i--) begin
      m_drv0 = !a[i];
      if (i == 0) probe(K_BUSY, 8'd0, "busy_before_match");
      tick();
    end
  endtask

  task automatic do_write(input logic [14:0] a, input logic [7:0] d, input logic match);
    send_addr(a, 1'b1);
    probe(K_BUSY, {7'b0, match}, "busy_after_wr_addr");
    for (int i = 7; i >= 0; i--) begin
      m_drv0 = !d[i];
      tick();
    end
`ifdef BUS_PARITY_EN
    m_drv0 = !((^d) ^ bad_par);
    tick();
    probe(K_PERR, {7'b0, match & bad_par}, "par_err_pulse");
`endif
    m_drv0 = 1'b0;
    probe(K_BUSY, {7'b0, match}, "busy_wr_done");
    bus_util = 1'b0;
    tick();
    probe(K_BUSY, 8'd0, "busy_wr_idle");
`ifdef BUS_PARITY_EN
    probe(K_PERR, 8'd0, "par_err_clear");
`endif
  endtask

  task automatic do_read(input logic [14:0] a, input logic [7:0] e, input logic match);
    send_addr(a, 1'b0);
    m_drv0 = 1'b0;
    probe(K_BUSY, {7'b0, match}, "busy_after_rd_addr");
    probe(K_BUS, 8'd1, "bus_turnaround");
    tick();
    byte_q.push_back(match ? e : 8'hFF);
    rd_phase = 1'b1;
    repeat (8) tick();
    rd_phase = 1'b0;
`ifdef BUS_PARITY_EN
    probe(K_BUS, {7'b0, match ? ^e : 1'b1}, "read_parity");
    tick();
`endif
    probe(K_BUSY, {7'b0, match}, "busy_rd_done");
    bus_util = 1'b0;
    tick();
    probe(K_BUSY, 8'd0, "busy_rd_idle");
  endtask

  task automatic dbg_chk(input logic [5:0] a, input logic [7:0] e, input string n);
    dbg_addr = a;
    tick();
    probe(K_DBG, e, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tick();
    probe(K_BUSY, 8'd0, "reset_busy");
    probe(K_BUS, 8'd1, "reset_bus");
    probe(K_DBG, 8'd0, "reset_dbg");
    probe(K_PERR, 8'd0, "reset_par_err");
    tick();
    rst = 1'b0;
    tick();

    do_write(15'h200A, 8'hCB, 1'b1);
    dbg_chk(6'd10, 8'hCB, "dbg_after_write");
    do_read(15'h200A, 8'hCB, 1'b1);

    do_write(15'h2FC5, 8'hA5, 1'b1);
    do_read(15'h2005, 8'hA5, 1'b1);
    dbg_chk(6'd5, 8'hA5, "dbg_alias");

    do_read(15'h600A, 8'h00, 1'b0);
    do_write(15'h600A, 8'h11, 1'b0);
    dbg_chk(6'd10, 8'hCB, "dbg_after_miss");

    send_addr(15'h200A, 1'b1);
    probe(K_BUSY, 8'd1, "busy_abort_addr");
    for (int i = 7; i >= 4; i--) begin
      m_drv0 = !(i[0]);
      tick();
    end
    m_drv0   = 1'b0;
    bus_util = 1'b0;
    probe(K_BUSY, 8'd1, "busy_before_abort");
    tick();
    probe(K_BUSY, 8'd0, "busy_after_abort");
    do_read(15'h200A, 8'hCB, 1'b1);
    dbg_chk(6'd10, 8'hCB, "dbg_after_abort");

    send_addr(15'h200A, 1'b0);
    m_drv0 = 1'b0;
    tick();
    probe(K_BUS, 8'd1, "rst_rd_bit7");
    tick();
    probe(K_BUS, 8'd1, "rst_rd_bit6");
    tick();
    probe(K_BUS, 8'd0, "rst_rd_bit5");
    tick();
    rst      = 1'b1;
    bus_util = 1'b0;
    probe(K_BUS, 8'd1, "rst_bus_released");
    probe(K_BUSY, 8'd0, "rst_busy_low");
    tick();
    rst = 1'b0;
    tick();
    do_write(15'h2001, 8'h3C, 1'b1);
    do_read(15'h2001, 8'h3C, 1'b1);
    dbg_chk(6'd1, 8'h3C, "dbg_after_rst");
    dbg_chk(6'd10, 8'hCB, "dbg_retained");

`ifdef BUS_PARITY_EN
    bad_par = 1'b1;
    do_write(15'h2001, 8'hCB, 1'b1);
    dbg_chk(6'd1, 8'h3C, "dbg_bad_parity");
    bad_par = 1'b0;
    do_write(15'h2001, 8'hCA, 1'b1);
    dbg_chk(6'd1, 8'hCA, "dbg_good_parity");
    do_read(15'h2001, 8'hCA, 1'b1);
`endif

    tick();
    tick();
    checks++;
    if ((exp_q.size() != 0) || (byte_q.size() != 0)) begin
      errors++;
      $display("FAIL drain: %0d probes and %0d bytes left, required 0", exp_q.size(), byte_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
